rv32im_csr_exec: RTL

CSR-instruction sequencer sitting directly upstream of `rv32im_csr`. It accepts a decoded CSRRW/CSRRS/CSRRC (register or immediate form) from the decode/issue stage over a valid/ready handshake. It performs the read-modify-write against the CSR file through that file's read and write strobes, applies the ISA rules for suppressed reads and writes and the privilege and read-only checks, and returns the old CSR value to writeback.

---
 rtl/rv32im_csr_exec.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rv32im_csr_exec.sv
// rv32im_csr_exec: CSR read-modify-write sequencer between issue and rv32im_csr.
// Revision 1.0
`default_nettype none

module rv32im_csr_exec #(
    parameter int API_XLEN  = 32,
    parameter int CSR_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           in_funct3_i,
    input  logic [CSR_WIDTH-1:0] in_addr_i,
    input  logic [API_XLEN-1:0]  in_rs1_val_i,
    input  logic [4:0]           in_rs1_idx_i,
    input  logic [4:0]           in_rd_idx_i,
    input  logic [1:0]           priv_i,
    input  logic                 flush_i,
    output logic [CSR_WIDTH-1:0] csr_addr_o,
    output logic [2:0]           csr_opcode_o,
    output logic                 re_csr_o,
    output logic                 we_csr_o,
    output logic [API_XLEN-1:0]  val_csr_o,
    input  logic [API_XLEN-1:0]  val_csr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [4:0]           rd_idx_o,
    output logic [API_XLEN-1:0]  rd_data_o,
    output logic                 rd_we_o,
    output logic                 illegal_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CSR_WIDTH-1:0]   addr_q;
    logic [2:0]             opcode_q;
    logic [API_XLEN-1:0]    src_q;
    logic [4:0]             rd_idx_q;
    logic                   do_read_q;
    logic                   do_write_q;
    logic                   re_q;
    logic                   we_q;
    logic [API_XLEN-1:0]    val_q;
    logic                   out_valid_q;
    logic [API_XLEN-1:0]    rd_data_q;
    logic                   rd_we_q;
    logic                   illegal_q;

    logic [API_XLEN-1:0]    acc_src_d;
    logic                   acc_is_rw_d;
    logic                   acc_do_read_d;
    logic                   acc_do_write_d;
    logic                   acc_illegal_d;
    logic [API_XLEN-1:0]    new_val_d;

    // Decode of the offered instruction; only consumed on the acceptance edge.
    always_comb begin
        acc_src_d      = in_funct3_i[2] ? {{(API_XLEN-5){1'b0}}, in_rs1_idx_i} : in_rs1_val_i;
        acc_is_rw_d    = (in_funct3_i[1:0] == 2'b01);
        acc_do_read_d  = !(acc_is_rw_d && (in_rd_idx_i == 5'd0));
        acc_do_write_d = acc_is_rw_d || (in_rs1_idx_i != 5'd0);
        acc_illegal_d  = (in_addr_i[9:8] > priv_i) ||
                         (acc_do_write_d && (in_addr_i[11:10] == 2'b11));
    end

    always_comb begin
        case (opcode_q[1:0])
            2'b10:   new_val_d = val_csr_i | src_q;
            2'b11:   new_val_d = val_csr_i & ~src_q;
            default: new_val_d = src_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            opcode_q    <= '0;
            src_q       <= '0;
            rd_idx_q    <= '0;
            do_read_q   <= 1'b0;
            do_write_q  <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            val_q       <= '0;
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        addr_q     <= in_addr_i;
                        opcode_q   <= in_funct3_i;
                        src_q      <= acc_src_d;
                        rd_idx_q   <= in_rd_idx_i;
                        do_read_q  <= acc_do_read_d;
                        do_write_q <= acc_do_write_d;
                        rd_data_q  <= '0;
                        if (acc_illegal_d) begin
                            state_q     <= S_RESP;
                            out_valid_q <= 1'b1;
                            illegal_q   <= 1'b1;
                            rd_we_q     <= 1'b0;
                        end else if (acc_do_read_d) begin
                            state_q <= S_READ;
                            re_q    <= 1'b1;
                        end else begin
                            // Write-only is always a plain RW, so the new value is src.
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                            val_q   <= acc_src_d;
                        end
                    end
                end
                S_READ: begin
                    state_q <= flush_i ? S_IDLE : S_CAPT;
                end
                S_CAPT: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rd_data_q <= val_csr_i;
                        if (do_write_q) begin
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                            val_q   <= new_val_d;
                        end else begin
                            state_q     <= S_RESP;
                            out_valid_q <= 1'b1;
                            rd_we_q     <= (rd_idx_q != 5'd0);
                        end
                    end
                end
                S_WRITE: begin
                    state_q     <= S_RESP;
                    out_valid_q <= 1'b1;
                    rd_we_q     <= do_read_q && (rd_idx_q != 5'd0);
                end
                S_RESP: begin
                    if (out_ready_i) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        rd_we_q     <= 1'b0;
                        illegal_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o   = (state_q == S_IDLE);
    assign csr_addr_o   = addr_q;
    assign csr_opcode_o = opcode_q;
    assign re_csr_o     = re_q;
    assign we_csr_o     = we_q;
    assign val_csr_o    = val_q;
    assign out_valid_o  = out_valid_q;
    assign rd_idx_o     = rd_idx_q;
    assign rd_data_o    = rd_data_q;
    assign rd_we_o      = rd_we_q;
    assign illegal_o    = illegal_q;

endmodule

`default_nettype wire
